// File: rtl/audio_adc_receiver.sv
// audio_adc_receiver: captures left-justified, MSB-first stereo ADC data from a
// WM8731 running as clock master. BCLK, ADCLRCK and ADCDAT are resynchronised
// into the clk domain. Completed frames are queued in a small first-word-fall-through
// FIFO that feeds a valid/ready output stream.
//
// Handshake: sample_valid is high whenever the FIFO holds a frame, and
// sample_left/sample_right show the head frame. The head is consumed on every
// clk edge where sample_valid && sample_ready are both high. Asserting
// sample_ready while the FIFO is empty has no effect.
module audio_adc_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          aud_bclk,
  input  logic                          aud_adclrck,
  input  logic                          aud_adcdat,
  output logic [DATA_WIDTH-1:0]         sample_left,
  output logic [DATA_WIDTH-1:0]         sample_right,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overrun,
  output logic                          frame_error,
  input  logic                          clear_errors,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int FW = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrc_sync, r_dat_sync;
  logic                   r_bclk_d, r_lrc_d;
  logic                   w_bclk_s, w_lrc_s, w_dat_s;
  logic                   w_bclk_rise, w_lrc_rise, w_lrc_fall;

  state_t                 r_state, w_state_next;
  logic [CW-1:0]          r_bit_cnt, w_cnt_base, w_cnt_next;
  logic [DATA_WIDTH-1:0]  r_left_sr, r_right_sr, w_left_next, w_right_next;
  logic                   r_bad, w_bad_next;
  logic                   w_capture, w_push, w_err_set;

  logic [FW-1:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_overrun, r_frame_error;
  logic                   w_full, w_pop, w_wr_en, w_overrun_set;

  // Identical synchroniser chains keep the three codec lines aligned; one extra flop per line gives edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bclk_sync <= '0;
      r_lrc_sync  <= '0;
      r_dat_sync  <= '0;
      r_bclk_d    <= 1'b0;
      r_lrc_d     <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], aud_bclk};
      r_lrc_sync  <= {r_lrc_sync[SYNC_STAGES-2:0], aud_adclrck};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], aud_adcdat};
      r_bclk_d    <= w_bclk_s;
      r_lrc_d     <= w_lrc_s;
    end
  end

  assign w_bclk_s    = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrc_s     = r_lrc_sync[SYNC_STAGES-1];
  assign w_dat_s     = r_dat_sync[SYNC_STAGES-1];
  assign w_bclk_rise = w_bclk_s & ~r_bclk_d;
  assign w_lrc_rise  = w_lrc_s & ~r_lrc_d;
  assign w_lrc_fall  = ~w_lrc_s & r_lrc_d;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_ALIGN;
    else          r_state <= w_state_next;
  end

  // Next state and capture control. The LRC edge is resolved first, so a BCLK rise in the same cycle becomes bit 0 of the new channel.
  always_comb begin
    w_state_next = r_state;
    w_cnt_base   = r_bit_cnt;
    w_bad_next   = r_bad;
    w_err_set    = 1'b0;
    case (r_state)
      ST_ALIGN: begin
        if (w_lrc_rise) begin
          w_state_next = ST_LEFT;
          w_cnt_base   = '0;
        end
      end
      ST_LEFT: begin
        if (w_lrc_fall) begin
          if (r_bit_cnt < CNT_FULL) begin
            w_err_set  = 1'b1;
            w_bad_next = 1'b1;
          end
          w_state_next = ST_RIGHT;
          w_cnt_base   = '0;
        end
      end
      ST_RIGHT: begin
        if (w_lrc_rise) begin
          if (r_bit_cnt < CNT_FULL) w_err_set = 1'b1;
          w_bad_next   = 1'b0;
          w_state_next = ST_LEFT;
          w_cnt_base   = '0;
        end
      end
      default: w_state_next = ST_ALIGN;
    endcase

    w_capture    = w_bclk_rise && (w_state_next != ST_ALIGN) && (w_cnt_base < CNT_FULL);
    w_cnt_next   = w_capture ? (w_cnt_base + CW'(1)) : w_cnt_base;
    w_left_next  = r_left_sr;
    w_right_next = r_right_sr;
    if (w_capture && (w_state_next == ST_LEFT))
      w_left_next = {r_left_sr[DATA_WIDTH-2:0], w_dat_s};
    if (w_capture && (w_state_next == ST_RIGHT))
      w_right_next = {r_right_sr[DATA_WIDTH-2:0], w_dat_s};
    // The frame completes on the last captured bit of the right channel.
    w_push = w_capture && (w_state_next == ST_RIGHT) && (w_cnt_base == CNT_LAST) && !w_bad_next;
  end

  // Bit counter, channel shift registers and the bad-frame marker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt  <= '0;
      r_left_sr  <= '0;
      r_right_sr <= '0;
      r_bad      <= 1'b0;
    end else begin
      r_bit_cnt  <= w_cnt_next;
      r_left_sr  <= w_left_next;
      r_right_sr <= w_right_next;
      r_bad      <= w_bad_next;
    end
  end

  assign w_full        = (r_count == LVL_FULL);
  assign w_pop         = sample_valid && sample_ready;
  assign w_wr_en       = w_push && (!w_full || w_pop);
  assign w_overrun_set = w_push && w_full && !w_pop;

  // FWFT frame FIFO. A push is accepted while full only if the head is popped in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= {r_left_sr, w_right_next};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_en && !w_pop)      r_count <= r_count + (AW + 1)'(1);
      else if (!w_wr_en && w_pop) r_count <= r_count - (AW + 1)'(1);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      if (w_overrun_set)     r_overrun <= 1'b1;
      else if (clear_errors) r_overrun <= 1'b0;
      if (w_err_set)         r_frame_error <= 1'b1;
      else if (clear_errors) r_frame_error <= 1'b0;
    end
  end

  assign sample_valid                = (r_count != '0);
  assign {sample_left, sample_right} = r_mem[r_rd_ptr];
  assign fill_level                  = r_count;
  assign overrun                     = r_overrun;
  assign frame_error                 = r_frame_error;
  assign dbg_state                   = r_state;

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Bench for audio_adc_receiver: drives a left-justified codec stream and checks
// the frame stream against a queue of expected frames, plus the flag and level
// behaviour around overrun, short channels and reset.
module tb_audio_adc_receiver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        aud_bclk, aud_adclrck, aud_adcdat;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, sample_ready;
  logic [2:0]  fill_level;
  logic        overrun, frame_error, clear_errors;
  logic [1:0]  dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_frame;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          lbits;
    int          rbits;
    bit          simul;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  audio_adc_receiver #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .aud_bclk     (aud_bclk),
    .aud_adclrck  (aud_adclrck),
    .aud_adcdat   (aud_adcdat),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fill_level   (fill_level),
    .overrun      (overrun),
    .frame_error  (frame_error),
    .clear_errors (clear_errors),
    .dbg_state    (dbg_state)
  );

  // Clock and global time limit.
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted frame must match the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got %h expected none", {sample_left, sample_right});
      end else begin
        exp_frame = exp_q.pop_front();
        check("frame", {sample_left, sample_right}, exp_frame);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic align();
    @(posedge clk);
    #3;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 sample_ready = v;
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #2 clear_errors = 1'b1;
    @(posedge clk);
    #2 clear_errors = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    aud_adcdat = b;
    #80 aud_bclk = 1'b1;
    #80 aud_bclk = 1'b0;
  endtask

  // One channel: bits beyond 16 are random filler the receiver must ignore.
  task automatic send_channel(input logic lr, input logic [15:0] val, input int nbits, input bit simul);
    int first;
    align();
    first = 0;
    if (simul) begin
      #80;
      aud_adcdat  = val[15];
      aud_adclrck = lr;
      aud_bclk    = 1'b1;
      #80 aud_bclk = 1'b0;
      first = 1;
    end else begin
      aud_adclrck = lr;
    end
    for (int i = first; i < nbits; i++)
      drive_bit((i < 16) ? val[15 - i] : 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lbits,
                            input int rbits, input bit simul, input bit exp_push);
    if (exp_push) exp_q.push_back({l, r});
    send_channel(1'b1, l, lbits, simul);
    send_channel(1'b0, r, rbits, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    wait_clks(2);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    aud_bclk     = 1'b0;
    aud_adclrck  = 1'b0;
    aud_adcdat   = 1'b0;
    sample_ready = 1'b0;
    clear_errors = 1'b0;

    vecs[0] = '{16'h1234, 16'hABCD, 16, 16, 1'b0, 1'b0};
    vecs[1] = '{16'h8000, 16'h7FFF, 24, 24, 1'b0, 1'b0};
    vecs[2] = '{16'h0FF0, 16'h0000, 10, 16, 1'b0, 1'b1};
    vecs[3] = '{16'h5555, 16'hAAAA, 16, 16, 1'b0, 1'b0};
    vecs[4] = '{16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 32, 32, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0001, 16, 20, 1'b1, 1'b0};

    // Reset values.
    wait_clks(4);
    #1;
    check("rst_valid", sample_valid, 0);
    check("rst_left", sample_left, 0);
    check("rst_right", sample_right, 0);
    check("rst_fill", fill_level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Tail of a right channel before any LRC rise must be ignored.
    align();
    aud_adclrck = 1'b0;
    for (int i = 0; i < 20; i++) drive_bit(1'($urandom_range(0, 1)));
    wait_clks(4);
    check("align_fill", fill_level, 0);
    check("align_state", dbg_state, 0);

    // Table of frames with ready held high.
    set_ready(1'b1);
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].l, vecs[v].r, vecs[v].lbits, vecs[v].rbits, vecs[v].simul,
                 (vecs[v].lbits >= 16) && (vecs[v].rbits >= 16));
      wait_clks(6);
      check($sformatf("vec%0d_frame_error", v), frame_error, vecs[v].exp_err);
      if (vecs[v].exp_err) begin
        pulse_clear();
        #1;
        check($sformatf("vec%0d_cleared", v), frame_error, 0);
      end
    end
    wait_drain("table_drain");
    check("table_overrun", overrun, 0);

    // Backpressure: six frames into a four-deep FIFO.
    set_ready(1'b0);
    for (int i = 1; i <= 6; i++)
      send_frame(16'(i), 16'(16'hF000 | i), 16, 16, 1'b0, i <= 4);
    wait_clks(6);
    check("bp_fill", fill_level, 4);
    check("bp_overrun", overrun, 1);
    check("bp_valid", sample_valid, 1);
    set_ready(1'b1);
    wait_drain("bp_drain");
    check("bp_fill_empty", fill_level, 0);
    pulse_clear();
    #1;
    check("bp_overrun_cleared", overrun, 0);

    // Full FIFO, frame completes in the very cycle the head is popped.
    set_ready(1'b0);
    for (int i = 0; i < 4; i++)
      send_frame(16'(16'h0A00 + i), 16'(16'h0B00 + i), 16, 16, 1'b0, 1'b1);
    wait_clks(6);
    check("pp_fill_before", fill_level, 4);
    exp_q.push_back({16'h0C0C, 16'h3C3C});
    send_channel(1'b1, 16'h0C0C, 16, 1'b0);
    align();
    aud_adclrck = 1'b0;
    for (int i = 0; i < 15; i++) drive_bit(16'h3C3C >> (15 - i));
    aud_adcdat = 1'b0;
    #80 aud_bclk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 sample_ready = 1'b1;
    @(posedge clk);
    #2 sample_ready = 1'b0;
    #5;
    check("pp_fill_after", fill_level, 4);
    check("pp_overrun", overrun, 0);
    #60 aud_bclk = 1'b0;
    set_ready(1'b1);
    wait_drain("pp_drain");

    // Reset in the middle of a right channel.
    set_ready(1'b0);
    send_frame(16'h1111, 16'h2222, 16, 16, 1'b0, 1'b0);
    send_channel(1'b1, 16'h3333, 10, 1'b0);
    send_channel(1'b0, 16'h4444, 8, 1'b0);
    wait_clks(4);
    check("pre_rst_fill", fill_level, 1);
    check("pre_rst_frame_error", frame_error, 1);
    reset_n = 1'b0;
    wait_clks(3);
    #1;
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_left", sample_left, 0);
    check("mid_rst_right", sample_right, 0);
    check("mid_rst_fill", fill_level, 0);
    check("mid_rst_frame_error", frame_error, 0);
    check("mid_rst_state", dbg_state, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    set_ready(1'b1);
    send_frame(16'hCAFE, 16'hBEEF, 16, 16, 1'b0, 1'b1);
    send_frame(16'h0F0F, 16'hF0F0, 16, 16, 1'b0, 1'b1);
    wait_drain("post_rst_drain");

    // Both sticky flags set, then one clear pulse.
    set_ready(1'b0);
    for (int i = 0; i < 5; i++)
      send_frame(16'(16'h7700 + i), 16'(16'h8800 + i), 16, 16, 1'b0, i < 4);
    send_frame(16'h9999, 16'h6666, 12, 16, 1'b0, 1'b0);
    wait_clks(4);
    check("both_overrun", overrun, 1);
    check("both_frame_error", frame_error, 1);
    pulse_clear();
    #1;
    check("both_overrun_cleared", overrun, 0);
    check("both_frame_error_cleared", frame_error, 0);
    set_ready(1'b1);
    wait_drain("final_drain");
    check("final_fill", fill_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
